// File: rtl/min_uint32_serial.sv
// rtl/min_uint32_serial.sv - bit-serial MSB-first unsigned minimum with valid/ready handshakes
// Optional MIN_SERIAL_EARLY_EXIT_EN: finish as soon as the first differing bit decides the result.
module min_uint32_serial #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Y,
  output logic             a_lt_b,
  output logic             a_eq_b
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CMP  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [IW-1:0]    idx;
  logic             decided;
  logic             lt;

  logic bit_a;
  logic bit_b;
  logic bit_diff;
  logic decided_next;
  logic lt_next;
  logic finish;

  // The first differing bit (MSB-first) fixes the ordering; later bits are ignored.
  always_comb begin
    bit_a        = a_r[idx];
    bit_b        = b_r[idx];
    bit_diff     = bit_a ^ bit_b;
    decided_next = decided | bit_diff;
    lt_next      = decided ? lt : (bit_diff & bit_b);
`ifdef MIN_SERIAL_EARLY_EXIT_EN
    finish       = (idx == '0) || (!decided && bit_diff);
`else
    finish       = (idx == '0);
`endif
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      a_r     <= '0;
      b_r     <= '0;
      idx     <= '0;
      decided <= 1'b0;
      lt      <= 1'b0;
      Y       <= '0;
      a_lt_b  <= 1'b0;
      a_eq_b  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_r     <= A;
            b_r     <= B;
            idx     <= IW'(WIDTH - 1);
            decided <= 1'b0;
            lt      <= 1'b0;
            state   <= S_CMP;
          end
        end
        S_CMP: begin
          decided <= decided_next;
          lt      <= lt_next;
          idx     <= idx - 1'b1;
          if (finish) begin
            Y      <= lt_next ? a_r : b_r;
            a_lt_b <= lt_next;
            a_eq_b <= !decided_next;
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_min_uint32_serial.sv
// tb/tb_min_uint32_serial.sv - randomized and directed bench for min_uint32_serial against a behavioural model
module tb_min_uint32_serial;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [W-1:0]  a_in = '0;
  logic [W-1:0]  b_in = '0;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  y_out;
  logic          a_lt_b;
  logic          a_eq_b;

  min_uint32_serial #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(a_in), .B(b_in), .out_valid(out_valid), .out_ready(out_ready),
    .Y(y_out), .a_lt_b(a_lt_b), .a_eq_b(a_eq_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int lat_of(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MIN_SERIAL_EARLY_EXIT_EN
    logic [W-1:0] d;
    d = a ^ b;
    for (int i = W - 1; i >= 0; i--)
      if (d[i]) return W - i;
    return W;
`else
    return (a == b) ? W : W;
`endif
  endfunction

  function automatic logic [W-1:0] min_of(input logic [W-1:0] a, input logic [W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  // Model: one operation in flight; result visible from t0+lat until accepted.
  bit           m_busy = 1'b0;
  int           m_t0 = 0;
  int           m_lat = 0;
  logic [W-1:0] m_cur_y = '0, m_prev_y = '0;
  logic         m_cur_lt = 1'b0, m_prev_lt = 1'b0, m_cur_eq = 1'b0, m_prev_eq = 1'b0;
  bit           m_done;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_busy = 1'b0;
      m_prev_y = '0; m_prev_lt = 1'b0; m_prev_eq = 1'b0;
      chk("rst_in_ready", W'(in_ready), W'(1));
      chk("rst_out_valid", W'(out_valid), W'(0));
      chk("rst_y", y_out, '0);
      chk("rst_lt", W'(a_lt_b), W'(0));
      chk("rst_eq", W'(a_eq_b), W'(0));
    end else begin
      m_done = m_busy && (cyc >= m_t0 + m_lat);
      chk("in_ready", W'(in_ready), W'(!m_busy));
      chk("out_valid", W'(out_valid), W'(m_done));
      chk("y", y_out, m_done ? m_cur_y : m_prev_y);
      chk("a_lt_b", W'(a_lt_b), W'(m_done ? m_cur_lt : m_prev_lt));
      chk("a_eq_b", W'(a_eq_b), W'(m_done ? m_cur_eq : m_prev_eq));
      if (!m_busy && in_valid) begin
        m_busy   = 1'b1;
        m_t0     = cyc + 1;
        m_lat    = lat_of(a_in, b_in);
        m_cur_y  = min_of(a_in, b_in);
        m_cur_lt = (a_in < b_in);
        m_cur_eq = (a_in == b_in);
      end else if (m_done && out_ready) begin
        m_busy    = 1'b0;
        m_prev_y  = m_cur_y;
        m_prev_lt = m_cur_lt;
        m_prev_eq = m_cur_eq;
      end
    end
  end

  // Runs one operation; hold>0 keeps out_ready low that many cycles after out_valid.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int hold, input bit pulse,
                        output logic [W-1:0] y, output logic lt, output logic eq, output int lat);
    int n;
    int t0;
    @(posedge clk); #1;
    a_in = a; b_in = b; in_valid = 1'b1; out_ready = (hold == 0);
    n = 0;
    do begin @(negedge clk); n++; end while (!(in_ready && in_valid) && n < 100);
    if (!in_ready) chk("in_handshake_timeout", W'(in_ready), W'(1));
    t0 = cyc + 1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 200) begin @(negedge clk); n++; end
    if (!out_valid) chk("out_valid_timeout", W'(out_valid), W'(1));
    lat = cyc - t0;
    y = y_out; lt = a_lt_b; eq = a_eq_b;
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        in_valid = pulse && (i == 2);
        a_in = 1; b_in = 2;
        @(negedge clk);
        chk("bp_y_stable", y_out, y);
        chk("bp_out_valid", W'(out_valid), W'(1));
        chk("bp_in_ready", W'(in_ready), W'(0));
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  logic [W-1:0] ry, ra, rb;
  logic         rlt, req;
  int           rlat, prev_hs, hs, exp_gap, prev_lat;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    run_op(32'd5, 32'd9, 0, 1'b0, ry, rlt, req, rlat);
    chk("p1_y", ry, 32'd5);
    chk("p1_lt", W'(rlt), W'(1));
    chk("p1_eq", W'(req), W'(0));
`ifdef MIN_SERIAL_EARLY_EXIT_EN
    chk("p1_lat", W'(rlat), W'(29));
`else
    chk("p1_lat", W'(rlat), W'(32));
`endif

    run_op(32'hFFFF_FFFF, 32'd0, 0, 1'b0, ry, rlt, req, rlat);
    chk("p2_y", ry, 32'd0);
    chk("p2_lt", W'(rlt), W'(0));
    chk("p2_eq", W'(req), W'(0));
`ifdef MIN_SERIAL_EARLY_EXIT_EN
    chk("p2_lat", W'(rlat), W'(1));
`else
    chk("p2_lat", W'(rlat), W'(32));
`endif

    run_op(32'h1234_5678, 32'h1234_5678, 0, 1'b0, ry, rlt, req, rlat);
    chk("p3_y", ry, 32'h1234_5678);
    chk("p3_lt", W'(rlt), W'(0));
    chk("p3_eq", W'(req), W'(1));
    chk("p3_lat", W'(rlat), W'(32));

    run_op(32'd100, 32'd40, 5, 1'b1, ry, rlt, req, rlat);
    chk("bp_y", ry, 32'd40);

    // Reset in the middle of an operation.
    @(posedge clk); #1;
    a_in = 32'hDEAD_BEEF; b_in = 32'h0000_1234; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", W'(out_valid), W'(0));
    chk("mid_rst_in_ready", W'(in_ready), W'(1));
    chk("mid_rst_y", y_out, '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run_op(32'd7, 32'd3, 0, 1'b0, ry, rlt, req, rlat);
    chk("post_rst_y", ry, 32'd3);
`ifdef MIN_SERIAL_EARLY_EXIT_EN
    chk("post_rst_lat", W'(rlat), W'(30));
`else
    chk("post_rst_lat", W'(rlat), W'(32));
`endif

    // Random operations with shared high bits and occasional equality.
    for (int k = 0; k < 10; k++) begin
      ra = $urandom;
      rb = (k % 3 == 0) ? ra : (ra ^ (32'h1 << $urandom_range(0, 31)));
      if (k % 4 == 1) rb = $urandom;
      run_op(ra, rb, $urandom_range(0, 3), 1'b1, ry, rlt, req, rlat);
      chk("rnd_y", ry, min_of(ra, rb));
    end

    // Streaming with in_valid and out_ready held high.
    @(posedge clk); #1;
    ra = $urandom; rb = $urandom;
    a_in = ra; b_in = rb; in_valid = 1'b1; out_ready = 1'b1;
    prev_hs = 0; prev_lat = 0;
    for (int k = 0; k < 8; k++) begin
      int n;
      n = 0;
      do begin @(negedge clk); n++; end while (!in_ready && n < 100);
      hs = cyc + 1;
      if (k > 0) begin
`ifdef MIN_SERIAL_EARLY_EXIT_EN
        exp_gap = prev_lat + 2;
`else
        exp_gap = 34;
`endif
        chk("stream_gap", W'(hs - prev_hs), W'(exp_gap));
      end
      prev_hs = hs;
      prev_lat = lat_of(ra, rb);
      @(posedge clk); #1;
      a_in = $urandom; b_in = $urandom;
      n = 0;
      while (!out_valid && n < 200) begin @(negedge clk); n++; end
      chk("stream_y", y_out, min_of(ra, rb));
      ra = a_in; rb = b_in;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (40) @(posedge clk);
    #1 out_ready = 1'b0;
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
